// File: rtl/code_entry_ctrl.sv
// Keypad-style code lock: two digit buttons plus submit, synchronized and edge-detected,
// with timed open / error / lockout phases and a consecutive-failure lockout counter.
module code_entry_ctrl #(
    parameter int WIDTH       = 5,
    parameter int OPEN_CYCLES = 16,
    parameter int ERR_CYCLES  = 8,
    parameter int FAILS_MAX   = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn0,
    input  logic                         btn1,
    input  logic                         btnEntry,
    input  logic [WIDTH-1:0]             code,
    output logic                         ledLight,
    output logic                         ledError,
    output logic                         ledLocked,
    output logic [$clog2(WIDTH+1)-1:0]   digitCount
);

    localparam int CW   = $clog2(WIDTH + 1);
    localparam int TMAX = (OPEN_CYCLES > ERR_CYCLES)
                        ? ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES)
                        : ((ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FW   = $clog2(FAILS_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_ERROR,
        S_LOCKED
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;
    logic [1:0] ready_reg;

    assign btn_raw = {btnEntry, btn1, btn0};

    // Edge detection stays disarmed until the synchronizers hold real samples,
    // so a button held through reset release never produces a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg <= 2'b00;
        end else begin
            ready_reg <= {ready_reg[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic prev_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg   <= 1'b1;
                    s2_reg   <= 1'b1;
                    prev_reg <= 1'b0;
                end else begin
                    s1_reg   <= btn_raw[gi];
                    s2_reg   <= s1_reg;
                    prev_reg <= ready_reg[1] & s2_reg;
                end
            end

            assign press[gi] = prev_reg & ~s2_reg;
        end
    endgenerate

    logic ev_entry;
    logic ev_one;
    logic ev_zero;
    logic ev_digit;

    assign ev_entry = press[2];
    assign ev_one   = press[1] & ~press[2];
    assign ev_zero  = press[0] & ~press[1] & ~press[2];
    assign ev_digit = ev_one | ev_zero;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  entry_reg, entry_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [FW-1:0]     fail_reg,  fail_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic              light_reg, error_reg, locked_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            entry_reg  <= '0;
            count_reg  <= '0;
            fail_reg   <= '0;
            timer_reg  <= '0;
            light_reg  <= 1'b0;
            error_reg  <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            entry_reg  <= entry_next;
            count_reg  <= count_next;
            fail_reg   <= fail_next;
            timer_reg  <= timer_next;
            light_reg  <= (state_next == S_OPEN);
            error_reg  <= (state_next == S_ERROR);
            locked_reg <= (state_next == S_LOCKED);
        end
    end

    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        count_next = count_reg;
        fail_next  = fail_reg;
        timer_next = timer_reg;

        case (state_reg)
            S_IDLE, S_ENTRY: begin
                if (ev_entry) begin
                    if (state_reg == S_ENTRY && count_reg == CW'(WIDTH)) begin
                        state_next = S_CHECK;
                    end else begin
                        // Premature submit: counts as a failure but never locks by itself.
                        state_next = S_ERROR;
                        timer_next = TW'(ERR_CYCLES - 1);
                        if (fail_reg < FW'(FAILS_MAX)) begin
                            fail_next = fail_reg + FW'(1);
                        end
                    end
                end else if (ev_digit) begin
                    state_next = S_ENTRY;
                    if (count_reg < CW'(WIDTH)) begin
                        entry_next = {entry_reg[WIDTH-2:0], ev_one};
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            S_CHECK: begin
                if (entry_reg == code) begin
                    state_next = S_OPEN;
                    timer_next = TW'(OPEN_CYCLES - 1);
                    fail_next  = '0;
                end else if (fail_reg >= FW'(FAILS_MAX - 1)) begin
                    state_next = S_LOCKED;
                    timer_next = TW'(LOCK_CYCLES - 1);
                    fail_next  = FW'(FAILS_MAX);
                end else begin
                    state_next = S_ERROR;
                    timer_next = TW'(ERR_CYCLES - 1);
                    fail_next  = fail_reg + FW'(1);
                end
            end
            S_OPEN: begin
                if (ev_entry || timer_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            S_ERROR: begin
                if (timer_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            S_LOCKED: begin
                if (timer_reg == '0) begin
                    state_next = S_IDLE;
                    fail_next  = '0;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Any attempt outcome discards the digits collected so far.
        if (state_next == S_OPEN || state_next == S_ERROR || state_next == S_LOCKED) begin
            entry_next = '0;
            count_next = '0;
        end
    end

    assign ledLight   = light_reg;
    assign ledError   = error_reg;
    assign ledLocked  = locked_reg;
    assign digitCount = count_reg;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboarded bench for code_entry_ctrl: stimulus queues expected LED phases from a
// digit-list model; a negedge monitor checks each phase's kind, length and digit count.
module tb_code_entry_ctrl;

    localparam int WIDTH  = 5;
    localparam int OPEN_C = 16;
    localparam int ERR_C  = 8;
    localparam int FMAX   = 3;
    localparam int LOCK_C = 64;
    localparam int K_OPEN = 0;
    localparam int K_ERR  = 1;
    localparam int K_LOCK = 2;

    typedef struct {
        int kind;
        int dur;
    } exp_t;

    logic                       clk;
    logic                       rst;
    logic                       btn0;
    logic                       btn1;
    logic                       btnEntry;
    logic [WIDTH-1:0]           code;
    logic                       ledLight;
    logic                       ledError;
    logic                       ledLocked;
    logic [$clog2(WIDTH+1)-1:0] digitCount;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   mq[$];
    int   fails    = 0;

    bit   mon_busy = 0;
    bit   have_cur = 0;
    exp_t cur;
    int   cnt      = 0;

    code_entry_ctrl #(
        .WIDTH      (WIDTH),
        .OPEN_CYCLES(OPEN_C),
        .ERR_CYCLES (ERR_C),
        .FAILS_MAX  (FMAX),
        .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn0      (btn0),
        .btn1      (btn1),
        .btnEntry  (btnEntry),
        .code      (code),
        .ledLight  (ledLight),
        .ledError  (ledError),
        .ledLocked (ledLocked),
        .digitCount(digitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s value=%0d t=%0t", name, act, $time);
        end
    endfunction

    // Monitor: one transaction per LED phase.
    always @(negedge clk) begin
        int hi;
        int k;
        hi = int'(ledLight) + int'(ledError) + int'(ledLocked);
        if (hi != 0 && !mon_busy) begin
            mon_busy = 1;
            cnt      = 1;
            k = ledLight ? K_OPEN : (ledError ? K_ERR : K_LOCK);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                have_cur = 0;
                $display("FAIL unexpected_led actual_kind=%0d expected=none t=%0t", k, $time);
            end else begin
                cur      = exp_q.pop_front();
                have_cur = 1;
                chk("led_kind", k, cur.kind);
                chk("led_onehot", hi, 1);
                chk("dc_at_phase", int'(digitCount), 0);
            end
        end else if (hi != 0) begin
            cnt++;
        end else if (mon_busy) begin
            mon_busy = 0;
            if (have_cur) chk("phase_len", cnt, cur.dur);
        end
    end

    task automatic press(input int mask, input int hold);
        @(negedge clk);
        if (mask[0]) btn0 = 1'b0;
        if (mask[1]) btn1 = 1'b0;
        if (mask[2]) btnEntry = 1'b0;
        repeat (hold) @(negedge clk);
        btn0 = 1'b1;
        btn1 = 1'b1;
        btnEntry = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic digit(input int d, input int mask);
        if (mq.size() < WIDTH) mq.push_back(d);
        press(mask, $urandom_range(1, 3));
        chk("digit_count", int'(digitCount), mq.size());
    endtask

    task automatic enter_bits(input int n, input logic [7:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            digit(int'(v[i]), v[i] ? 2 : 1);
        end
    endtask

    task automatic submit(input int mask, input bit wait_done);
        exp_t e;
        int   acc;
        if (mq.size() == WIDTH) begin
            acc = 0;
            foreach (mq[i]) acc = acc * 2 + mq[i];
            if (acc == int'(code)) begin
                e.kind = K_OPEN; e.dur = OPEN_C; fails = 0;
            end else begin
                fails++;
                if (fails >= FMAX) begin
                    e.kind = K_LOCK; e.dur = LOCK_C; fails = 0;
                end else begin
                    e.kind = K_ERR; e.dur = ERR_C;
                end
            end
        end else begin
            e.kind = K_ERR; e.dur = ERR_C;
            if (fails < FMAX) fails++;
        end
        mq.delete();
        exp_q.push_back(e);
        press(mask, $urandom_range(1, 3));
        if (wait_done) repeat (e.dur + 6) @(negedge clk);
    endtask

    initial begin
        int c;
        int n;
        logic [7:0] v;
        btn0 = 1'b1; btn1 = 1'b1; btnEntry = 1'b1;
        rst  = 1'b0;
        code = 5'b01011;
        repeat (3) @(negedge clk);
        chk("rst_leds_low", int'({ledLight, ledError, ledLocked}), 0);
        chk("rst_dc_low", int'(digitCount), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_leds_after", int'({ledLight, ledError, ledLocked}), 0);
        chk("rst_dc_after", int'(digitCount), 0);

        // Correct code, then a wrong one, then correct again to clear failures
        enter_bits(5, 8'b01011); submit(4, 1);
        chk("dc_after_open", int'(digitCount), 0);
        enter_bits(5, 8'b00001); submit(4, 1);
        enter_bits(5, 8'b01011); submit(4, 1);

        // Three wrong codes -> lockout, presses ignored, then correct code opens
        enter_bits(5, 8'b11110); submit(4, 1);
        enter_bits(5, 8'b10100); submit(4, 1);
        enter_bits(5, 8'b11111); submit(4, 0);
        press(1, 1); chk("dc_in_lock_b0", int'(digitCount), 0);
        press(2, 1); chk("dc_in_lock_b1", int'(digitCount), 0);
        press(4, 1); chk("dc_in_lock_entry", int'(digitCount), 0);
        repeat (LOCK_C) @(negedge clk);
        enter_bits(5, 8'b01011); submit(4, 1);

        // Same-cycle btn0 + btnEntry with four digits held: submit wins
        enter_bits(4, 8'b0101); submit(5, 1);
        chk("dc_after_simul", int'(digitCount), 0);

        // Overflow digits ignored, then cancel the open phase early
        enter_bits(7, 8'b0101100);
        chk("dc_saturated", int'(digitCount), WIDTH);
        c = $urandom_range(0, 8);
        mq.delete(); fails = 0;
        exp_q.push_back('{K_OPEN, c + 3});
        press(4, 1);
        for (int k = 0; k < 20 && ledLight !== 1'b1; k++) @(negedge clk);
        repeat (c) @(negedge clk);
        btnEntry = 1'b0;
        @(negedge clk);
        btnEntry = 1'b1;
        repeat (OPEN_C + 6) @(negedge clk);
        chk("dc_after_cancel", int'(digitCount), 0);

        // Reset mid-entry
        enter_bits(3, 8'b010);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_leds", int'({ledLight, ledError, ledLocked}), 0);
        chk("midrst_dc", int'(digitCount), 0);
        mq.delete(); fails = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_dc_after", int'(digitCount), 0);
        enter_bits(5, 8'b01011); submit(4, 1);

        // Button held through reset release must not register
        @(negedge clk);
        btn0 = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_thru_rst", int'(digitCount), 0);
        btn0 = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_release", int'(digitCount), 0);
        digit(0, 1);
        submit(4, 1);

        // Randomized attempts
        for (int t = 0; t < 25; t++) begin
            code = WIDTH'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                n = WIDTH;
                v = {3'b000, code};
            end else begin
                n = $urandom_range(0, 7);
                v = 8'($urandom);
            end
            for (int i = n - 1; i >= 0; i--) begin
                if (v[i]) digit(1, ($urandom_range(0, 9) == 0) ? 3 : 2);
                else      digit(0, 1);
            end
            submit(4, 1);
        end

        for (int k = 0; k < 200 && (exp_q.size() != 0 || mon_busy); k++) @(negedge clk);
        chk("scoreboard_drain", exp_q.size() + int'(mon_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_entry_ctrl.md
CODE_ENTRY_CTRL -- requirements
Module: code_entry_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning digits per code.
REQ-002 SHALL have parameter OPEN_CYCLES, default 16, meaning clk cycles ledLight stays on after a match.
REQ-003 SHALL have parameter ERR_CYCLES, default 8, meaning clk cycles ledError stays on after a failed attempt.
REQ-004 SHALL have parameter FAILS_MAX, default 3, meaning consecutive failures that trigger lockout.
REQ-005 SHALL have parameter LOCK_CYCLES, default 64, meaning lockout duration in clk cycles.
REQ-006 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port btn0, input, 1, active-low "enter digit 0" button, asynchronous to clk.
REQ-009 SHALL have port btn1, input, 1, active-low "enter digit 1" button, asynchronous to clk.
REQ-010 SHALL have port btnEntry, input, 1, active-low "submit / relock" button, asynchronous to clk.
REQ-011 SHALL have port code, input, WIDTH, the stored secret; first-entered digit compares against code[WIDTH-1].
REQ-012 SHALL have port ledLight, output, 1, high while unlocked (state OPEN).
REQ-013 SHALL have port ledError, output, 1, high during state ERROR.
REQ-014 SHALL have port ledLocked, output, 1, high during state LOCKED.
REQ-015 SHALL have port digitCount, output, $clog2(WIDTH+1), number of digits held.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer, reset to 1, then falling-edge detect; one press event per low pulse regardless of pulse length (>= 1 clk period).
REQ-017 SHALL act on a press event no later than the 3rd rising clk edge after the input falls.
REQ-018 SHALL resolve same-cycle events by priority btnEntry > btn1 > btn0; lower-priority events in that cycle are discarded.
REQ-019 SHALL implement states IDLE, ENTRY, CHECK, OPEN, ERROR, LOCKED; reset state IDLE.
REQ-020 SHALL, in IDLE or ENTRY, on a digit event shift the digit into the LSB of the entry register (left shift), increment digitCount, go ENTRY.
REQ-021 SHALL ignore digit events once digitCount == WIDTH (count saturates, register unchanged).
REQ-022 SHALL, on btnEntry in ENTRY with digitCount == WIDTH, go CHECK for exactly one cycle and compare the entry register against code sampled in that cycle.
REQ-023 SHALL, on btnEntry in IDLE or in ENTRY with digitCount < WIDTH, go ERROR and count it as a failure.
REQ-024 SHALL, on match, go OPEN and clear the failure counter; on mismatch, increment the failure counter and go ERROR, or LOCKED if the counter reaches FAILS_MAX.
REQ-025 SHALL clear the entry register and digitCount on leaving CHECK, ERROR, and LOCKED.
REQ-026 SHALL hold OPEN for OPEN_CYCLES cycles then go IDLE; btnEntry in OPEN returns to IDLE on the next edge; digit events in OPEN are ignored.
REQ-027 SHALL hold ERROR for ERR_CYCLES cycles then go IDLE; all events in ERROR are ignored.
REQ-028 SHALL hold LOCKED for LOCK_CYCLES cycles ignoring all events, then go IDLE with the failure counter cleared.
REQ-029 SHALL drive ledLight, ledError, ledLocked as registered decodes of the state, mutually exclusive.
REQ-030 SHALL size the dwell timer for max(OPEN_CYCLES, ERR_CYCLES, LOCK_CYCLES) and reload it on each state entry.

Reset
REQ-031 SHALL, on rst low, immediately clear state to IDLE, the entry register, digitCount, failure counter, and timer, and set synchronizer flops to 1.
REQ-032 SHALL drive ledLight = 0, ledError = 0, ledLocked = 0, digitCount = 0 while rst is low and after release.
REQ-033 SHALL generate no press event on rst release while a button is held low; the press registers only after release and re-press.

Verification
REQ-034 SHALL verify: code=01011, presses 0,1,0,1,1, then Entry -> ledLight = 1 for 16 cycles, then 0, digitCount = 0.
REQ-035 SHALL verify: code=01011, presses 0,0,0,0,1, then Entry -> ledError = 1 for 8 cycles, failure count = 1.
REQ-036 SHALL verify: three consecutive wrong codes (11110, 10100, 11111) -> third attempt gives ledLocked = 1 for 64 cycles with buttons ignored, then a correct 01011 gives ledLight = 1.
REQ-037 SHALL verify: btn0 and btnEntry fall in the same cycle with 4 digits held -> treated as Entry only -> ERROR, digitCount = 0.
REQ-038 SHALL verify: 7 digit presses 0,1,0,1,1,0,0, then Entry -> extra digits ignored -> ledLight = 1; Entry during OPEN -> ledLight = 0 on the next edge.
REQ-039 SHALL verify: rst pulsed low mid-entry after 3 digits -> all outputs 0, digitCount = 0; a full 01011 entry afterwards opens.
